// File: rtl/comparator_pkg.sv
// Shared types and elaboration helpers for the pipelined magnitude comparator.
package comparator_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 128;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  function automatic int levels_per_stage(input int width, input int stages);
    return ($clog2(width) + stages - 1) / stages;
  endfunction

  // Bit offset of stage s inside the packed stage-register vector; stage i
  // keeps width >> (last tree level it completes) (lt,gt) pairs.
  function automatic int stage_off(input int width, input int stages, input int s);
    int lps;
    int lvls;
    int e;
    int off;
    lps  = levels_per_stage(width, stages);
    lvls = $clog2(width);
    off  = 0;
    for (int i = 0; i < s; i++) begin
      e   = ((i + 1) * lps < lvls) ? (i + 1) * lps : lvls;
      off = off + (width >> e);
    end
    return off;
  endfunction

endpackage

// File: rtl/cmp_merge_level.sv
// One combinational comparator tree level: folds PAIRS (lt,gt) pairs into PAIRS/2.
module cmp_merge_level
  import comparator_pkg::*;
#(
  parameter int PAIRS = 2
) (
  input  logic [PAIRS-1:0]   lt_in,
  input  logic [PAIRS-1:0]   gt_in,
  output logic [PAIRS/2-1:0] lt_out,
  output logic [PAIRS/2-1:0] gt_out
);

  // The more significant pair decides unless it reports equality.
  for (genvar i = 0; i < PAIRS / 2; i++) begin : g_pair
    assign lt_out[i] = lt_in[2*i+1] | (~gt_in[2*i+1] & lt_in[2*i]);
    assign gt_out[i] = gt_in[2*i+1] | (~lt_in[2*i+1] & gt_in[2*i]);
  end

endmodule

// File: rtl/comparator_pipe.sv
// Pipelined signed/unsigned comparator with valid/ready flow control.
// Optional Min/Max outputs are built when CMP_MINMAX_EN is defined.
module comparator_pipe
  import comparator_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAGW-1:0]  InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             EQ,
  output logic             LT,
  output logic             LTu,
  output logic [TAGW-1:0]  OutTag
`ifdef CMP_MINMAX_EN
  ,
  input  logic             Signed,
  output logic [WIDTH-1:0] Min,
  output logic [WIDTH-1:0] Max
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LPS    = levels_per_stage(WIDTH, STAGES);
  localparam int RW     = stage_off(WIDTH, STAGES, STAGES);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "comparator_pipe: WIDTH must be a power of two in [4,128]");
  end
  if (STAGES < 1 || STAGES > LEVELS) begin : g_bad_stages
    $fatal(1, "comparator_pipe: STAGES must be in [1,$clog2(WIDTH)]");
  end

  logic                 adv;
  logic [WIDTH-1:0]     bit_lt_u, bit_gt_u, bit_lt_s, bit_gt_s;
  logic [WIDTH-2:0]     lv_lt_u, lv_gt_u, lv_lt_s, lv_gt_s;
  logic [RW-1:0]        lt_u_nxt, gt_u_nxt, lt_s_nxt, gt_s_nxt;
  logic [RW-1:0]        lt_u_p, gt_u_p, lt_s_p, gt_s_p;
  logic [STAGES-1:0]    vld_p;
  logic [TAGW-1:0]      tag_p [STAGES];
  cmp_flags_t           flags;
  logic                 unused_gt_s;

  assign adv     = ~vld_p[STAGES-1] | OutReady;
  assign InReady = adv;

  // Per-bit (lt,gt); the signed chain flips the sign bit's sense.
  assign bit_lt_u = ~A & B;
  assign bit_gt_u = A & ~B;
  assign bit_lt_s = {A[WIDTH-1] & ~B[WIDTH-1], bit_lt_u[WIDTH-2:0]};
  assign bit_gt_s = {~A[WIDTH-1] & B[WIDTH-1], bit_gt_u[WIDTH-2:0]};

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int NI = WIDTH >> (k - 1);
    localparam int NO = WIDTH >> k;
    localparam int OO = WIDTH - NI;
    logic [NI-1:0] lt_u_i, gt_u_i, lt_s_i, gt_s_i;

    if (k == 1) begin : g_src_in
      assign lt_u_i = bit_lt_u;
      assign gt_u_i = bit_gt_u;
      assign lt_s_i = bit_lt_s;
      assign gt_s_i = bit_gt_s;
    end else if ((k - 1) % LPS == 0) begin : g_src_reg
      localparam int RO = stage_off(WIDTH, STAGES, (k - 1) / LPS - 1);
      assign lt_u_i = lt_u_p[RO +: NI];
      assign gt_u_i = gt_u_p[RO +: NI];
      assign lt_s_i = lt_s_p[RO +: NI];
      assign gt_s_i = gt_s_p[RO +: NI];
    end else begin : g_src_lv
      localparam int IO = WIDTH - (WIDTH >> (k - 2));
      assign lt_u_i = lv_lt_u[IO +: NI];
      assign gt_u_i = lv_gt_u[IO +: NI];
      assign lt_s_i = lv_lt_s[IO +: NI];
      assign gt_s_i = lv_gt_s[IO +: NI];
    end

    cmp_merge_level #(.PAIRS(NI)) u_unsigned (
      .lt_in (lt_u_i),
      .gt_in (gt_u_i),
      .lt_out(lv_lt_u[OO +: NO]),
      .gt_out(lv_gt_u[OO +: NO])
    );
    cmp_merge_level #(.PAIRS(NI)) u_signed (
      .lt_in (lt_s_i),
      .gt_in (gt_s_i),
      .lt_out(lv_lt_s[OO +: NO]),
      .gt_out(lv_gt_s[OO +: NO])
    );
  end

  // Stage boundaries: each register captures its last completed tree level;
  // a stage left without levels just forwards its predecessor.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int E  = ((s + 1) * LPS < LEVELS) ? (s + 1) * LPS : LEVELS;
    localparam int SW = WIDTH >> E;
    localparam int RO = stage_off(WIDTH, STAGES, s);

    if (s * LPS + 1 <= LEVELS) begin : g_from_lv
      localparam int LO = WIDTH - (WIDTH >> (E - 1));
      assign lt_u_nxt[RO +: SW] = lv_lt_u[LO +: SW];
      assign gt_u_nxt[RO +: SW] = lv_gt_u[LO +: SW];
      assign lt_s_nxt[RO +: SW] = lv_lt_s[LO +: SW];
      assign gt_s_nxt[RO +: SW] = lv_gt_s[LO +: SW];
    end else begin : g_pass
      localparam int PO = stage_off(WIDTH, STAGES, s - 1);
      assign lt_u_nxt[RO +: SW] = lt_u_p[PO +: SW];
      assign gt_u_nxt[RO +: SW] = gt_u_p[PO +: SW];
      assign lt_s_nxt[RO +: SW] = lt_s_p[PO +: SW];
      assign gt_s_nxt[RO +: SW] = gt_s_p[PO +: SW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= InValid;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      lt_u_p   <= lt_u_nxt;
      gt_u_p   <= gt_u_nxt;
      lt_s_p   <= lt_s_nxt;
      gt_s_p   <= gt_s_nxt;
      tag_p[0] <= InTag;
      for (int s = 1; s < STAGES; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // Output stage: results are masked so an idle or freshly reset pipe reads 0.
  assign OutValid    = vld_p[STAGES-1];
  assign flags.eq    = OutValid & ~(lt_u_p[RW-1] | gt_u_p[RW-1]);
  assign flags.lt    = OutValid & lt_s_p[RW-1];
  assign flags.ltu   = OutValid & lt_u_p[RW-1];
  assign unused_gt_s = gt_s_p[RW-1];
  assign EQ          = flags.eq;
  assign LT          = flags.lt;
  assign LTu         = flags.ltu;
  assign OutTag      = OutValid ? tag_p[STAGES-1] : '0;

`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] a_p [STAGES];
  logic [WIDTH-1:0] b_p [STAGES];
  logic [STAGES-1:0] sgn_p;
  logic             sel_lt;

  always_ff @(posedge clk) begin
    if (adv) begin
      a_p[0]   <= A;
      b_p[0]   <= B;
      sgn_p[0] <= Signed;
      for (int s = 1; s < STAGES; s++) begin
        a_p[s]   <= a_p[s-1];
        b_p[s]   <= b_p[s-1];
        sgn_p[s] <= sgn_p[s-1];
      end
    end
  end

  // On equality both selections yield A's value.
  assign sel_lt = sgn_p[STAGES-1] ? lt_s_p[RW-1] : lt_u_p[RW-1];
  assign Min    = OutValid ? (sel_lt ? a_p[STAGES-1] : b_p[STAGES-1]) : '0;
  assign Max    = OutValid ? (sel_lt ? b_p[STAGES-1] : a_p[STAGES-1]) : '0;
`endif

endmodule

// File: tb/tb_comparator_pipe.sv
// Scoreboard bench for comparator_pipe (WIDTH=64, STAGES=2); Min/Max are
// checked as well when CMP_MINMAX_EN is defined.
module tb_comparator_pipe;

  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAGW   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             InValid = 1'b0;
  logic             OutReady = 1'b1;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [TAGW-1:0]  InTag = '0;
  logic             sgn = 1'b0;
  logic             InReady, OutValid, EQ, LT, LTu;
  logic [TAGW-1:0]  OutTag;
`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] Min, Max;
`endif

  always #5 clk = ~clk;

  comparator_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk     (clk),
    .reset   (reset),
    .InValid (InValid),
    .InReady (InReady),
    .A       (A),
    .B       (B),
    .InTag   (InTag),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .EQ      (EQ),
    .LT      (LT),
    .LTu     (LTu),
    .OutTag  (OutTag)
`ifdef CMP_MINMAX_EN
    ,
    .Signed  (sgn),
    .Min     (Min),
    .Max     (Max)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             sgn;
    logic [WIDTH-1:0] mn;
    logic [WIDTH-1:0] mx;
  } vec_t;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SMIN = 64'h8000_0000_0000_0000;
  localparam logic [WIDTH-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;

  vec_t vt [16];
  vec_t sb [$];
  vec_t mon_e;
  int   pop_cyc [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && OutValid && OutReady) begin
      checks++;
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag=%0d, required no result", OutTag);
      end else begin
        mon_e = sb.pop_front();
        if ({EQ, LT, LTu, OutTag} !== {mon_e.eq, mon_e.lt, mon_e.ltu, mon_e.tag}
`ifdef CMP_MINMAX_EN
            || Min !== mon_e.mn || Max !== mon_e.mx
`endif
           ) begin
          errors++;
          $display("FAIL result_tag%0d: got eq=%0b lt=%0b ltu=%0b tag=%0d, required eq=%0b lt=%0b ltu=%0b tag=%0d",
                   mon_e.tag, EQ, LT, LTu, OutTag, mon_e.eq, mon_e.lt, mon_e.ltu, mon_e.tag);
`ifdef CMP_MINMAX_EN
          $display("  min=%h max=%h, required min=%h max=%h", Min, Max, mon_e.mn, mon_e.mx);
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic send(input int i, input bit push);
    int n = 0;
    A = vt[i].a;
    B = vt[i].b;
    InTag = vt[i].tag;
    sgn = vt[i].sgn;
    InValid = 1'b1;
    while (!InReady && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!InReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got InReady=0 for %0d cycles, required 1", n);
    end else if (push) begin
      sb.push_back(vt[i]);
    end
    @(posedge clk); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    int p0;
    int gaps;
    int ghosts;
    //          a                        b                        tag eq lt ltu sgn min                      max
    vt[0]  = '{64'd5,                   64'd5,                   4'd3,  1, 0, 0, 0, 64'd5,                   64'd5};
    vt[1]  = '{SMIN,                    64'd0,                   4'd1,  0, 1, 0, 0, 64'd0,                   SMIN};
    vt[2]  = '{64'd0,                   SMIN,                    4'd2,  0, 0, 1, 0, 64'd0,                   SMIN};
    vt[3]  = '{64'd0,                   64'd1,                   4'd4,  0, 1, 1, 0, 64'd0,                   64'd1};
    vt[4]  = '{ONES,                    64'd1,                   4'd5,  0, 1, 0, 1, ONES,                    64'd1};
    vt[5]  = '{ONES,                    64'd1,                   4'd6,  0, 1, 0, 0, 64'd1,                   ONES};
    vt[6]  = '{64'd1,                   ONES,                    4'd7,  0, 0, 1, 0, 64'd1,                   ONES};
    vt[7]  = '{SMAX,                    SMIN,                    4'd8,  0, 0, 1, 1, SMIN,                    SMAX};
    vt[8]  = '{64'd123,                 64'd122,                 4'd9,  0, 0, 0, 0, 64'd122,                 64'd123};
    vt[9]  = '{64'hFFFF_FFFF_FFFF_FFFE, ONES,                    4'd10, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, ONES};
    vt[10] = '{64'h0000_0010_0000_0000, 64'h0000_000F_FFFF_FFFF, 4'd11, 0, 0, 0, 0, 64'h0000_000F_FFFF_FFFF, 64'h0000_0010_0000_0000};
    vt[11] = '{64'h0000_0000_0001_0000, 64'h0000_0000_0001_0001, 4'd12, 0, 1, 1, 0, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0001};
    vt[12] = '{64'd0,                   64'd0,                   4'd13, 1, 0, 0, 0, 64'd0,                   64'd0};
    vt[13] = '{64'h8000_0000_0000_0001, SMIN,                    4'd14, 0, 0, 0, 1, SMIN,                    64'h8000_0000_0000_0001};
    vt[14] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 4'd15, 0, 0, 1, 0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
    vt[15] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 4'd0,  0, 1, 0, 1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_outvalid", OutValid, 0);
    chk("reset_flags", {EQ, LT, LTu, OutTag}, 0);
    chk("reset_inready", InReady, 1);

    // single op: result presented exactly two cycles after presentation
    send(0, 1);
    chk("latency_cycle1", OutValid, 0);
    @(posedge clk); #1;
    chk("latency_cycle2", {OutValid, EQ, LT, LTu, OutTag}, {1'b1, 1'b1, 1'b0, 1'b0, 4'd3});
    wait_empty();
    send(1, 1);
    send(2, 1);
    wait_empty();

    // back-to-back burst of 8
    p0 = pop_cyc.size();
    for (int i = 3; i <= 10; i++) send(i, 1);
    wait_empty();
    chk("burst_count", pop_cyc.size() - p0, 8);
    gaps = 0;
    for (int i = p0 + 1; i < pop_cyc.size(); i++)
      if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
    chk("burst_consecutive", gaps, 0);

    // stall with a third operand waiting at the input
    OutReady = 1'b0;
    send(11, 1);
    send(12, 1);
    A = vt[13].a;
    B = vt[13].b;
    InTag = vt[13].tag;
    sgn = vt[13].sgn;
    InValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_inready", InReady, 0);
      chk("stall_hold", {OutValid, EQ, LT, LTu, OutTag}, {1'b1, 1'b0, 1'b1, 1'b1, 4'd12});
      @(posedge clk); #1;
    end
    OutReady = 1'b1;
    sb.push_back(vt[13]);
    @(posedge clk); #1;
    InValid = 1'b0;
    wait_empty();
    repeat (2) @(posedge clk);
    #1;

    // reset with one op in the pipe and another being presented
    send(14, 0);
    A = vt[15].a;
    B = vt[15].b;
    InTag = vt[15].tag;
    InValid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_flush", OutValid, 0);
    reset = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    chk("ready_after_reset", InReady, 1);
    chk("flags_after_reset", {EQ, LT, LTu, OutTag}, 0);
    OutReady = 1'b1;
    ghosts = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (OutValid) ghosts++;
    end
    chk("no_ghost_results", ghosts, 0);
    @(posedge clk); #1;

    send(14, 1);
    send(15, 1);
    wait_empty();
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/comparator_pipe.md
COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 Parameter WIDTH, default 64, sets the operand width; legal values are powers of two, 4 to 128.
REQ-002 Parameter STAGES, default 2, sets the number of register stages; legal values are 1 to $clog2(WIDTH).
REQ-003 Parameter TAGW, default 4, sets the width of the sideband tag.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 InValid  in  1  operand pair A/B/InTag is presented.
REQ-007 InReady  out  1  the block accepts an operand pair this cycle.
REQ-008 A, B  in  WIDTH  the operands.
REQ-009 InTag  in  TAGW  sideband tag, returned unchanged with the result.
REQ-010 OutValid  out  1  a result is presented.
REQ-011 OutReady  in  1  the consumer takes the result this cycle.
REQ-012 EQ, LT, LTu  out  1 each  A==B; A<B signed; A<B unsigned.
REQ-013 OutTag  out  TAGW  tag of the presented result.

Function
REQ-014 A transfer occurs on the input when InValid&InReady, and on the output when OutValid&OutReady.
REQ-015 Global advance enable: adv = ~OutValid | OutReady; InReady = adv.
REQ-016 When adv=1, every stage loads from its predecessor (stage 0 loads from the inputs), and each stage's valid bit is loaded from its predecessor's valid bit (stage 0's from InValid).
REQ-017 When adv=0, all stages hold their data, tags and valid bits.
REQ-018 Latency is exactly STAGES cycles from input transfer to OutValid when there is no stall; throughput is one result per cycle.
REQ-019 Tree levels: level 1 applies a 2-bit magnitude compare per bit pair; each higher level merges adjacent (lt,gt) pairs, with the upper pair taking priority.
REQ-020 Signed ordering substitutes {~A[MSB],A[MSB-1]} / {~B[MSB],B[MSB-1]} for the top bit pair in a parallel signed chain.
REQ-021 The $clog2(WIDTH) tree levels are split across STAGES register boundaries, with ceil(levels/STAGES) levels per stage and the final stage holding any remainder.
REQ-022 EQ = ~(lt|gt) of the unsigned chain.
REQ-023 LT and LTu are registered outputs and do not depend combinationally on A or B.
REQ-024 Accepting new input and emitting a result in the same cycle is legal and loses no data.
REQ-025 Output data holds stable while OutValid=1 and OutReady=0.

Reset
REQ-026 With reset=1 at a clock edge, all stage valid bits clear to 0, so OutValid=0.
REQ-027 After reset, EQ, LT, LTu and OutTag read 0.
REQ-028 Operations in flight when reset asserts are discarded; no partial result appears.
REQ-029 InReady is 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With macro CMP_MINMAX_EN defined, the block adds these ports and pipes A and B through the stages:
- input Signed (1 bit);
- outputs Min and Max (WIDTH each).
REQ-031 Min/Max follow LT when Signed=1 and LTu when Signed=0; on equality, Min=Max=A.
REQ-032 Without CMP_MINMAX_EN, the Signed, Min and Max ports and the operand pipeline registers do not exist.

Structure
REQ-033 Package comparator_pkg holds:
- cmp_flags_t, a struct of eq, lt and ltu;
- the function that computes levels-per-stage;
- the localparams MIN_WIDTH=4 and MAX_WIDTH=128.
REQ-034 One sub-module, cmp_merge_level, holds one combinational tree level, parameterised by its input pair count; comparator_pipe instantiates it per level in a generate loop.
REQ-035 An elaboration-time assertion rejects an illegal WIDTH or STAGES.

Verification
REQ-036 WIDTH=64, STAGES=2, OutReady=1: A=5, B=5, tag 3 -> two cycles later OutValid=1, EQ=1, LT=0, LTu=0, OutTag=3.
REQ-037 A=64'h8000_0000_0000_0000, B=0 -> LT=1, LTu=0; swapping the operands gives LT=0, LTu=1.
REQ-038 Back-to-back inputs for 8 cycles with OutReady=1 -> 8 consecutive results, in order, with matching tags.
REQ-039 Stall: OutReady=0 for 3 cycles while OutValid=1 -> InReady=0, outputs stable; OutReady=1 then resumes with no loss or duplication.
REQ-040 reset asserted with 2 operations in flight -> OutValid=0 next cycle; neither result ever appears.
REQ-041 CMP_MINMAX_EN defined, Signed=1, A=-1, B=1 -> Min=-1, Max=1; Signed=0 gives Min=1, Max=all-ones.
